// File: rtl/ram1i1o_strm_pkg.sv
// Shared encodings and helpers for the ram1i1o streaming access engine.
package ram1i1o_strm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_FILL = 2'd2
    } state_e;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_FILL = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < n) r = b + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram1i1o.sv
// Single-port RAM: synchronous write, combinational read at the same address.
module ram1i1o
    import ram1i1o_strm_pkg::*;
#(
    parameter int SZ = 2,
    parameter int DW = 32,
    localparam int AW = clog2(SZ)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] o
);

    logic [DW-1:0] mem [SZ];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= i;
    end

    assign o = mem[addr_i];

endmodule

// File: rtl/ram1i1o_strm_oreg.sv
// One-entry valid/ready output register for the read stream.
// Handshake: a word transfers on any edge where stb & rdy; while stb & ~rdy,
// stb and dout hold. load may refill in the same cycle a word is consumed.
module ram1i1o_strm_oreg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          rdy,
    output logic          stb,
    output logic [DW-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb  <= 1'b0;
            dout <= '0;
        end else if (clr) begin
            stb <= 1'b0;
        end else if (load) begin
            stb  <= 1'b1;
            dout <= din;
        end else if (stb && rdy) begin
            stb <= 1'b0;
        end
    end

endmodule

// File: rtl/ram1i1o_strm.sv
// Command sequencer driving a ram1i1o: streams a run of words out on a
// valid/ready port, or fills a run of words with a constant.
module ram1i1o_strm
    import ram1i1o_strm_pkg::*;
#(
    parameter int SZ = 2,
    parameter int DW = 32,
    localparam int AW = clog2(SZ)
) (
    input  logic          rst_i,
    input  logic          clk_i,
    input  logic          cmd_stb_i,
    output logic          cmd_rdy_o,
    input  logic          cmd_op_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [AW:0]   cmd_len_i,
    input  logic [DW-1:0] cmd_data_i,
    input  logic          abort_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_i_o,
    input  logic [DW-1:0] ram_o_i,
    output logic          dat_stb_o,
    input  logic          dat_rdy_i,
    output logic [DW-1:0] dat_o,
    output logic          done_o
);

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [AW-1:0] ADDR_TOP = AW'(SZ - 1);

    // state is the debug-visible FSM register (typed state_e).
    state_e        state, state_nx;
    logic [AW-1:0] addr_q, addr_nx, addr_inc;
    logic [AW:0]   len_q, len_nx, cnt_q, cnt_nx;
    logic [DW-1:0] data_q, data_nx;
    logic          done_q, done_nx;
    logic          free, load, clr;

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    assign addr_inc = (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_ONE;
    assign free     = !dat_stb_o || dat_rdy_i;
    assign load     = (state == ST_READ) && !abort_i && free && (cnt_q < len_q);
    assign clr      = (state != ST_IDLE) && abort_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            len_q  <= len_nx;
            cnt_q  <= cnt_nx;
            data_q <= data_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        len_nx   = len_q;
        cnt_nx   = cnt_q;
        data_nx  = data_q;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_stb_i) begin
                    addr_nx = cmd_addr_i;
                    len_nx  = cmd_len_i;
                    data_nx = cmd_data_i;
                    cnt_nx  = '0;
                    if (cmd_len_i == '0)        done_nx  = 1'b1;
                    else if (cmd_op_i == OP_FILL) state_nx = ST_FILL;
                    else                          state_nx = ST_READ;
                end
            end
            ST_FILL: begin
                if (abort_i) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    addr_nx = addr_inc;
                    cnt_nx  = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (abort_i) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    if (load) begin
                        addr_nx = addr_inc;
                        cnt_nx  = cnt_q + CNT_ONE;
                    end
                    // Retire once the final word leaves the output register.
                    if (dat_stb_o && dat_rdy_i && (cnt_q == len_q)) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    ram1i1o_strm_oreg #(.DW(DW)) u_oreg (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clr   (clr),
        .load  (load),
        .din   (ram_o_i),
        .rdy   (dat_rdy_i),
        .stb   (dat_stb_o),
        .dout  (dat_o)
    );

    assign cmd_rdy_o  = (state == ST_IDLE);
    assign ram_we_o   = (state == ST_FILL);
    assign ram_addr_o = addr_q;
    assign ram_i_o    = data_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ram1i1o_strm.sv
// Self-checking bench for ram1i1o_strm with an attached 16x32 ram1i1o.
module tb_ram1i1o_strm;
    import ram1i1o_strm_pkg::*;

    localparam int SZ = 16;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          cmd_stb_i = 1'b0;
    logic          cmd_rdy_o;
    logic          cmd_op_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [AW:0]   cmd_len_i = '0;
    logic [DW-1:0] cmd_data_i = '0;
    logic          abort_i = 1'b0;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_i_o;
    logic [DW-1:0] ram_o;
    logic          dat_stb_o;
    logic          dat_rdy_i = 1'b0;
    logic [DW-1:0] dat_o;
    logic          done_o;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model [SZ];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram1i1o_strm #(.SZ(SZ), .DW(DW)) dut (
        .rst_i      (rst_i),
        .clk_i      (clk),
        .cmd_stb_i  (cmd_stb_i),
        .cmd_rdy_o  (cmd_rdy_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_data_i (cmd_data_i),
        .abort_i    (abort_i),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_i_o    (ram_i_o),
        .ram_o_i    (ram_o),
        .dat_stb_o  (dat_stb_o),
        .dat_rdy_i  (dat_rdy_i),
        .dat_o      (dat_o),
        .done_o     (done_o)
    );

    ram1i1o #(.SZ(SZ), .DW(DW)) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we_o),
        .addr_i (ram_addr_o),
        .i      (ram_i_o),
        .o      (ram_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_rdy"}, 64'(cmd_rdy_o), 64'(1));
        chk({tag, "_we"}, 64'(ram_we_o), 64'(0));
        chk({tag, "_addr"}, 64'(ram_addr_o), 64'(0));
        chk({tag, "_wdata"}, 64'(ram_i_o), 64'(0));
        chk({tag, "_stb"}, 64'(dat_stb_o), 64'(0));
        chk({tag, "_dat"}, 64'(dat_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
    endtask

    // Drives one command in the current cycle; returns one cycle later.
    task automatic issue(input logic op, input int a, input int len, input logic [DW-1:0] d);
        chk("cmd_rdy_before_issue", 64'(cmd_rdy_o), 64'(1));
        cmd_stb_i  = 1'b1;
        cmd_op_i   = op;
        cmd_addr_i = AW'(a);
        cmd_len_i  = (AW+1)'(len);
        cmd_data_i = d;
        step();
        cmd_stb_i  = 1'b0;
        cmd_op_i   = 1'b0;
        cmd_addr_i = '0;
        cmd_len_i  = '0;
        cmd_data_i = '0;
    endtask

    // Fill a run; abort_at (1-based write index) of 0 means no abort.
    task automatic do_fill(input int a, input int len, input logic [DW-1:0] d, input int abort_at);
        int n;
        n = (abort_at != 0) ? abort_at : len;
        issue(OP_FILL, a, len, d);
        for (int w = 1; w <= n; w++) begin
            chk("fill_we", 64'(ram_we_o), 64'(1));
            chk("fill_addr", 64'(ram_addr_o), 64'((a + w - 1) % SZ));
            chk("fill_wdata", 64'(ram_i_o), 64'(d));
            chk("fill_done_early", 64'(done_o), 64'(0));
            if (w == abort_at) abort_i = 1'b1;
            step();
        end
        abort_i = 1'b0;
        chk("fill_done", 64'(done_o), 64'(1));
        chk("fill_we_after", 64'(ram_we_o), 64'(0));
        chk("fill_cmd_rdy_after", 64'(cmd_rdy_o), 64'(1));
        chk("fill_stb", 64'(dat_stb_o), 64'(0));
        for (int k = 0; k < n; k++) model[(a + k) % SZ] = d;
    endtask

    // mode 0: always ready, 1: repeating 1,0,0 pattern, 2: random ready.
    task automatic do_read(input int a, input int len, input int mode);
        int cyc, hs, last_hs_cyc;
        logic prev_hold, done_seen;
        logic [DW-1:0] prev_dat;
        exp_q.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(model[(a + k) % SZ]);
        issue(OP_READ, a, len, DW'($urandom));
        cyc = 1;
        hs = 0;
        last_hs_cyc = 0;
        prev_hold = 1'b0;
        prev_dat = '0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 20 * len + 20) begin
            case (mode)
                0: dat_rdy_i = 1'b1;
                1: dat_rdy_i = ((cyc % 3) == 1);
                default: dat_rdy_i = 1'($urandom_range(0, 1));
            endcase
            if (prev_hold) begin
                chk("read_hold_stb", 64'(dat_stb_o), 64'(1));
                chk("read_hold_dat", 64'(dat_o), 64'(prev_dat));
            end
            chk("read_we", 64'(ram_we_o), 64'(0));
            if (done_o) begin
                done_seen = 1'b1;
            end else if (dat_stb_o && dat_rdy_i) begin
                if (exp_q.size() == 0) chk("read_extra_word", 64'(dat_o), 64'(0) - 64'(1));
                else chk("read_data", 64'(dat_o), 64'(exp_q.pop_front()));
                hs++;
                last_hs_cyc = cyc;
                if (mode == 0) chk("read_beat_cycle", 64'(cyc), 64'(hs + 1));
            end
            prev_hold = dat_stb_o && !dat_rdy_i;
            prev_dat = dat_o;
            if (!done_seen) begin
                step();
                cyc++;
            end
        end
        dat_rdy_i = 1'b0;
        if (!done_seen) begin
            chk("read_timeout", 64'(0), 64'(1));
        end else begin
            chk("read_handshakes", 64'(hs), 64'(len));
            chk("read_words_left", 64'(exp_q.size()), 64'(0));
            chk("read_cmd_rdy_at_done", 64'(cmd_rdy_o), 64'(1));
            chk("read_stb_at_done", 64'(dat_stb_o), 64'(0));
            if (len == 0) chk("read_done_cycle", 64'(cyc), 64'(1));
            else chk("read_done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
            if (mode == 0 && len > 0) chk("read_done_cycle", 64'(cyc), 64'(len + 2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, a, len, mode, ab;
        logic [DW-1:0] d;

        // Reset.
        step();
        chk_idle_outputs("in_reset");
        @(negedge clk) rst_i = 1'b1;
        step();
        chk_idle_outputs("after_reset");

        // Fill 3..6 with a constant, then read it back.
        do_fill(3, 4, 32'hA5A5_A5A5, 0);
        step();
        chk("fill_done_one_cycle", 64'(done_o), 64'(0));
        do_read(3, 4, 0);

        // Preload RAM[k] = k.
        for (int k = 0; k < SZ; k++) do_fill(k, 1, DW'(k), 0);

        // Wrap-around read, back-pressured read.
        do_read(14, 4, 0);
        do_read(5, 3, 1);

        // Zero-length commands of both kinds.
        do_fill(9, 0, 32'hDEAD_BEEF, 0);
        chk("zero_fill_no_write", 64'(model[9]), 64'(9));
        do_read(2, 0, 0);
        step();
        chk("zero_done_one_cycle", 64'(done_o), 64'(0));

        // Fill len 8 aborted at the third write; next command accepted at done.
        do_fill(8, 8, 32'h1234_5678, 3);
        do_read(7, 5, 0);

        // Abort a read with a word pending.
        issue(OP_READ, 0, 5, '0);
        dat_rdy_i = 1'b0;
        step();
        chk("rabort_stb", 64'(dat_stb_o), 64'(1));
        chk("rabort_dat", 64'(dat_o), 64'(model[0]));
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("rabort_stb_dropped", 64'(dat_stb_o), 64'(0));
        chk("rabort_done", 64'(done_o), 64'(1));
        chk("rabort_cmd_rdy", 64'(cmd_rdy_o), 64'(1));
        step();
        chk("rabort_done_one_cycle", 64'(done_o), 64'(0));
        chk("idle_abort_no_effect", 64'(cmd_rdy_o), 64'(1));

        // Reset mid-read with a word pending.
        issue(OP_READ, 2, 4, '0);
        step();
        chk("rst_read_stb_before", 64'(dat_stb_o), 64'(1));
        rst_i = 1'b0;
        #1;
        chk_idle_outputs("rst_read");
        @(negedge clk) rst_i = 1'b1;
        step();
        chk_idle_outputs("rst_read_release");

        // Reset mid-fill: two writes land before reset.
        issue(OP_FILL, 12, 6, 32'hCAFE_0001);
        step();
        step();
        chk("rst_fill_we_before", 64'(ram_we_o), 64'(1));
        rst_i = 1'b0;
        #1;
        chk_idle_outputs("rst_fill");
        model[12] = 32'hCAFE_0001;
        model[13] = 32'hCAFE_0001;
        @(negedge clk) rst_i = 1'b1;
        step();
        chk_idle_outputs("rst_fill_release");
        do_read(11, 5, 2);

        // Random command mix.
        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 1);
            a = $urandom_range(0, SZ - 1);
            len = $urandom_range(0, SZ);
            d = DW'($urandom);
            if (op == 1) begin
                ab = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(1, len) : 0;
                do_fill(a, len, d, ab);
            end else begin
                mode = $urandom_range(0, 2);
                do_read(a, len, mode);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
        do_read(0, SZ, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
